// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg -- shared definitions for the frequency-counter gate controller.
//
// Holds the FSM state encoding and the default gate-length width and edge-wait
// timeout. The SPI register map imports this package so that its status
// readback decode always matches the controller.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package fc_pkg;

   localparam int unsigned FC_STATE_W        = 3;
   localparam int unsigned FC_GATE_W_DEF     = 24;
   localparam int unsigned FC_TO_CYCLES_DEF  = 10000000;

   // Reciprocal counting sequence: arm, open on a signal edge, hold for the
   // gate length, then close on the next signal edge.
   typedef enum logic [FC_STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_GATE  = 3'd2,
      S_CLOSE = 3'd3,
      S_DONE  = 3'd4
   } fc_state_e;

endpackage : fc_pkg

// File: rtl/fc_timer.sv
// -----------------------------------------------------------------------------
// fc_timer -- loadable down-counter with zero flag.
//
// Load has priority over enable. When enabled, the count decrements once per
// cycle and stops at zero rather than wrapping.
//
// Ports:
//   i_clk   in  1  clock (rising edge)
//   i_rst   in  1  synchronous active-high reset, clears the count
//   i_load  in  1  load i_val into the count
//   i_en    in  1  decrement enable
//   i_val   in  W  load value
//   o_zero  out 1  count is zero
// -----------------------------------------------------------------------------
module fc_timer #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule : fc_timer

// File: rtl/fc_gate_ctrl.sv
// -----------------------------------------------------------------------------
// fc_gate_ctrl -- gate controller for a reciprocal frequency counter.
//
// After a start request the controller arms and waits for a signal edge, opens
// the gate for the latched number of clk cycles, then keeps the counters
// enabled until the next signal edge closes the measurement. Counter clear and
// enable are registered and never overlap.
//
// Optional feature: define FC_GATE_CTRL_TIMEOUT_EN to add an edge-wait timeout
// in ARM and CLOSE (TO_CYCLES cycles). Without it those states wait forever and
// timeout is tied low.
//
// Ports:
//   clk       in  1       system clock
//   rst       in  1       synchronous active-high reset
//   start     in  1       measurement request (accepted only in IDLE)
//   abort     in  1       cancel, returns to IDLE, wins over everything but rst
//   gate_len  in  GATE_W  gate length in clk cycles, 0 treated as 1
//   sig_edge  in  1       synchronized rising-edge strobe of measured signal
//   cnt_clr   out 1       clear event/reference counters
//   cnt_en    out 1       enable event/reference counters
//   busy      out 1       controller not in IDLE
//   done      out 1       one-cycle completion pulse
//   timeout   out 1       sticky timeout status
//   state     out 3       current state code
// -----------------------------------------------------------------------------
module fc_gate_ctrl
   import fc_pkg::*;
#(
   parameter int unsigned GATE_W    = FC_GATE_W_DEF,
   parameter int unsigned TO_CYCLES = FC_TO_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [GATE_W-1:0]     gate_len,
   input  logic                  sig_edge,
   output logic                  cnt_clr,
   output logic                  cnt_en,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [FC_STATE_W-1:0] state
);

   fc_state_e        r_state;
   logic [GATE_W-1:0] r_len;
   logic             r_cnt_clr;
   logic             r_cnt_en;
   logic             r_busy;
   logic             r_done;

   // ---------------------------------------------------------------------------
   // Gate timer: loaded with len-1 on the ARM->GATE transition so the zero flag
   // is seen in the last GATE cycle, giving exactly len GATE cycles.
   // ---------------------------------------------------------------------------
   logic w_gate_load;
   logic w_gate_en;
   logic w_gate_zero;

   assign w_gate_load = !abort && (r_state == S_ARM) && sig_edge;
   assign w_gate_en   = (r_state == S_GATE);

   fc_timer #(.W(GATE_W)) u_gate_timer (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (w_gate_load),
      .i_en   (w_gate_en),
      .i_val  (r_len - GATE_W'(1)),
      .o_zero (w_gate_zero)
   );

`ifdef FC_GATE_CTRL_TIMEOUT_EN
   // ---------------------------------------------------------------------------
   // Edge-wait counter: restarted on entry to ARM and to CLOSE, expires on the
   // TO_CYCLES-th waiting cycle. A coincident edge takes precedence.
   // ---------------------------------------------------------------------------
   localparam int unsigned TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

   logic w_wait_load;
   logic w_wait_en;
   logic w_wait_zero;
   logic r_timeout;

   assign w_wait_load = !abort &&
                        (((r_state == S_IDLE) && start) ||
                         ((r_state == S_GATE) && w_gate_zero));
   assign w_wait_en   = (r_state == S_ARM) || (r_state == S_CLOSE);

   fc_timer #(.W(TO_W)) u_wait_timer (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (w_wait_load),
      .i_en   (w_wait_en),
      .i_val  (TO_W'(TO_CYCLES - 1)),
      .o_zero (w_wait_zero)
   );

   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Control FSM, all outputs registered.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_len     <= '0;
         r_cnt_clr <= 1'b0;
         r_cnt_en  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef FC_GATE_CTRL_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
      end else if (abort) begin
         // Timeout status is sticky and survives an abort.
         r_state   <= S_IDLE;
         r_cnt_clr <= 1'b0;
         r_cnt_en  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         // Clear and done are single-cycle pulses by construction.
         r_cnt_clr <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len     <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                  r_state   <= S_ARM;
                  r_cnt_clr <= 1'b1;
                  r_busy    <= 1'b1;
`ifdef FC_GATE_CTRL_TIMEOUT_EN
                  r_timeout <= 1'b0;
`endif
               end
            end
            S_ARM: begin
               if (sig_edge) begin
                  r_state  <= S_GATE;
                  r_cnt_en <= 1'b1;
               end
`ifdef FC_GATE_CTRL_TIMEOUT_EN
               else if (w_wait_zero) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end
`endif
            end
            S_GATE: begin
               if (w_gate_zero) begin
                  r_state <= S_CLOSE;
               end
            end
            S_CLOSE: begin
               if (sig_edge) begin
                  r_state  <= S_DONE;
                  r_cnt_en <= 1'b0;
                  r_done   <= 1'b1;
               end
`ifdef FC_GATE_CTRL_TIMEOUT_EN
               else if (w_wait_zero) begin
                  r_state   <= S_DONE;
                  r_cnt_en  <= 1'b0;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end
`endif
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state  <= S_IDLE;
               r_cnt_en <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign cnt_clr = r_cnt_clr;
   assign cnt_en  = r_cnt_en;
   assign busy    = r_busy;
   assign done    = r_done;
   assign state   = r_state;

endmodule : fc_gate_ctrl
